// File: rtl/mux_interleave_n.sv
// mux_interleave_n: N-lane to 1 time-division interleaver with per-lane FIFOs.
// Round-robin slot pointer, fixed-slot or work-conserving skip mode.
//
// Ports:
//   clk_4f    - single fast clock, rising edge
//   reset_L   - asynchronous active-low reset
//   data_in   - packed lane words, lane i at [i*DATA_W +: DATA_W]
//   valid_in  - per-lane write strobe
//   in_ready  - per-lane FIFO not full
//   mode_skip - 0 = fixed-slot, 1 = skip empty lanes
//   data_out  - interleaved word (registered)
//   valid_out - data_out carries a valid word
//   lane_out  - lane index of the current output slot
//   overflow  - sticky per-lane write-while-full flag
module mux_interleave_n #(
  parameter int LANES      = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk_4f,
  input  logic                       reset_L,
  input  logic [LANES*DATA_W-1:0]    data_in,
  input  logic [LANES-1:0]           valid_in,
  output logic [LANES-1:0]           in_ready,
  input  logic                       mode_skip,
  output logic [DATA_W-1:0]          data_out,
  output logic                       valid_out,
  output logic [$clog2(LANES)-1:0]   lane_out,
  output logic [LANES-1:0]           overflow
);

  localparam int LANE_W = $clog2(LANES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [LANES][FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wp  [LANES];
  logic [PTR_W-1:0]  r_rp  [LANES];
  logic [CNT_W-1:0]  r_cnt [LANES];
  logic [LANE_W-1:0] r_p;
  logic [LANES-1:0]  r_ovf;

  logic [LANES-1:0]  w_full;
  logic [LANES-1:0]  w_empty;
  logic [LANES-1:0]  w_push;
  logic [LANES-1:0]  w_pop;
  logic              w_found;
  logic [LANE_W-1:0] w_sel;
  logic [LANE_W-1:0] w_idx;
  logic [LANE_W-1:0] w_p_nxt;
  logic [DATA_W-1:0] w_head;

  // Full is judged on the registered count only, so a
  // same-cycle pop never lets an extra write in.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_full[i]  = (r_cnt[i] == CNT_W'(FIFO_DEPTH));
      w_empty[i] = (r_cnt[i] == '0);
      w_push[i]  = valid_in[i] && !w_full[i];
    end
  end

  assign in_ready = ~w_full;
  assign overflow = r_ovf;

  // Skip mode: scan downward so the nearest non-empty
  // lane after the pointer wins the last assignment.
  always_comb begin
    w_sel   = r_p;
    w_idx   = r_p;
    w_found = !w_empty[r_p];
    if (mode_skip) begin
      w_found = 1'b0;
      for (int k = LANES - 1; k >= 0; k--) begin
        w_idx = r_p + LANE_W'(k);
        if (!w_empty[w_idx]) begin
          w_found = 1'b1;
          w_sel   = w_idx;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_pop[i] = w_found && (w_sel == LANE_W'(i));
    end
  end

  assign w_head = r_mem[w_sel][r_rp[w_sel]];

  always_comb begin
    w_p_nxt = r_p + LANE_W'(1);
    if (mode_skip) begin
      w_p_nxt = w_found ? w_sel + LANE_W'(1) : r_p;
    end
  end

  // Storage needs no reset: counts gate every read.
  always_ff @(posedge clk_4f) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wp[i]] <= data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < LANES; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
      r_p       <= '0;
      r_ovf     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      lane_out  <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (w_push[i]) begin
          r_wp[i] <= r_wp[i] + PTR_W'(1);
        end
        if (w_pop[i]) begin
          r_rp[i] <= r_rp[i] + PTR_W'(1);
        end
        r_cnt[i] <= r_cnt[i] + CNT_W'(w_push[i])
                    - CNT_W'(w_pop[i]);
        if (valid_in[i] && w_full[i]) begin
          r_ovf[i] <= 1'b1;
        end
      end
      r_p       <= w_p_nxt;
      valid_out <= w_found;
      data_out  <= w_found ? w_head : '0;
      lane_out  <= w_found ? w_sel : r_p;
    end
  end

endmodule

// File: tb/tb_mux_interleave_n.sv
// tb_mux_interleave_n: randomized and directed checks of mux_interleave_n
// against a queue-based reference model of the interleaver.
module tb_mux_interleave_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4 = 1'b1;
  logic [31:0] d4_din = '0;
  logic [3:0]  d4_vin = '0;
  logic        d4_skip = 1'b0;
  logic [3:0]  d4_rdy;
  logic [7:0]  d4_dout;
  logic        d4_vout;
  logic [1:0]  d4_lane;
  logic [3:0]  d4_ovf;

  logic         rst8 = 1'b1;
  logic [127:0] d8_din = '0;
  logic [7:0]   d8_vin = '0;
  logic         d8_skip = 1'b0;
  logic [7:0]   d8_rdy;
  logic [15:0]  d8_dout;
  logic         d8_vout;
  logic [2:0]   d8_lane;
  logic [7:0]   d8_ovf;

  mux_interleave_n #(.LANES(4), .DATA_W(8), .FIFO_DEPTH(4)) u_dut4 (
    .clk_4f(clk), .reset_L(rst4), .data_in(d4_din),
    .valid_in(d4_vin), .in_ready(d4_rdy), .mode_skip(d4_skip),
    .data_out(d4_dout), .valid_out(d4_vout), .lane_out(d4_lane),
    .overflow(d4_ovf)
  );

  mux_interleave_n #(.LANES(8), .DATA_W(16), .FIFO_DEPTH(4)) u_dut8 (
    .clk_4f(clk), .reset_L(rst8), .data_in(d8_din),
    .valid_in(d8_vin), .in_ready(d8_rdy), .mode_skip(d8_skip),
    .data_out(d8_dout), .valid_out(d8_vout), .lane_out(d8_lane),
    .overflow(d8_ovf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per lane, slot pointer as integer.
  logic [15:0] mq [8][$];
  int          mp;
  logic [7:0]  movf;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mq[i].delete();
    mp   = 0;
    movf = '0;
  endtask

  task automatic model_step(input int nl, input logic [7:0][15:0] w,
                            input logic [7:0] v, input bit sk,
                            output bit ev, output logic [15:0] ed,
                            output int el);
    int sz[8];
    int s;
    bit f;
    for (int i = 0; i < 8; i++) sz[i] = mq[i].size();
    f = 0;
    s = mp;
    if (!sk) begin
      f = sz[mp] > 0;
    end else begin
      for (int k = 0; k < nl; k++) begin
        if (!f && sz[(mp + k) % nl] > 0) begin
          f = 1;
          s = (mp + k) % nl;
        end
      end
    end
    ev = f;
    ed = '0;
    el = f ? s : mp;
    if (f) ed = mq[s].pop_front();
    if (!sk) mp = (mp + 1) % nl;
    else if (f) mp = (s + 1) % nl;
    for (int i = 0; i < nl; i++) begin
      if (v[i]) begin
        if (sz[i] < 4) mq[i].push_back(w[i]);
        else movf[i] = 1'b1;
      end
    end
  endtask

  function automatic logic [7:0] exp_rdy(input int nl);
    logic [7:0] r = '0;
    for (int i = 0; i < nl; i++) r[i] = mq[i].size() < 4;
    return r;
  endfunction

  function automatic bit busy(input int nl);
    bit b = 0;
    for (int i = 0; i < nl; i++) if (mq[i].size() > 0) b = 1;
    return b;
  endfunction

  task automatic step4(input logic [7:0][15:0] w, input logic [3:0] v,
                       input bit sk, output bit ev,
                       output logic [15:0] ed, output int el);
    for (int i = 0; i < 4; i++) d4_din[i*8 +: 8] = w[i][7:0];
    d4_vin  = v;
    d4_skip = sk;
    @(posedge clk);
    model_step(4, w, {4'b0, v}, sk, ev, ed, el);
    #1;
  endtask

  task automatic step8(input logic [7:0][15:0] w, input logic [7:0] v,
                       input bit sk, output bit ev,
                       output logic [15:0] ed, output int el);
    d8_din  = w;
    d8_vin  = v;
    d8_skip = sk;
    @(posedge clk);
    model_step(8, w, v, sk, ev, ed, el);
    #1;
  endtask

  task automatic align4();
    bit ev;
    logic [15:0] ed;
    int el;
    int n = 0;
    while ((mp != 0 || busy(4)) && n < 64) begin
      step4('0, '0, 1'b0, ev, ed, el);
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL align: drain took %0d cycles, limit 64", n);
    end
  endtask

  task automatic test_reset();
    #1 rst4 = 1'b0;
    rst8 = 1'b0;
    #2;
    checks++;
    if ({d4_vout, d4_dout, d4_lane, d4_ovf} !== 15'd0 ||
        d4_rdy !== 4'hF) begin
      errors++;
      $display("FAIL reset4: v/d/l/o/r=%b/%h/%0d/%b/%b want 0/0/0/0/1111",
               d4_vout, d4_dout, d4_lane, d4_ovf, d4_rdy);
    end
    checks++;
    if ({d8_vout, d8_dout, d8_lane, d8_ovf} !== 28'd0 ||
        d8_rdy !== 8'hFF) begin
      errors++;
      $display("FAIL reset8: v/d/l/o/r=%b/%h/%0d/%b/%b want 0/0/0/0/ff",
               d8_vout, d8_dout, d8_lane, d8_ovf, d8_rdy);
    end
    @(posedge clk);
    #1 rst4 = 1'b1;
    rst8 = 1'b1;
    model_reset();
  endtask

  task automatic test_legacy();
    logic [7:0][15:0] w;
    logic [7:0] tbl [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    bit ev;
    logic [15:0] ed;
    int el;
    w = '0;
    for (int i = 0; i < 4; i++) w[i] = {8'h0, tbl[i]};
    for (int c = 0; c < 16; c++) begin
      step4(w, (c % 4 == 0) ? 4'hF : 4'h0, 1'b0, ev, ed, el);
      checks++;
      if (d4_vout !== ev || d4_dout !== ed[7:0] ||
          d4_lane !== 2'(el) || d4_rdy !== exp_rdy(4)[3:0]) begin
        errors++;
        $display("FAIL legacy c=%0d: v/d/l/r=%b/%h/%0d/%b want %b/%h/%0d",
                 c, d4_vout, d4_dout, d4_lane, d4_rdy, ev, ed[7:0], el);
      end
      if (c >= 1) begin
        checks++;
        if (d4_vout !== 1'b1 || d4_lane !== 2'(c % 4) ||
            d4_dout !== tbl[c % 4]) begin
          errors++;
          $display("FAIL legacy_stream c=%0d: v/d/l=%b/%h/%0d want 1/%h/%0d",
                   c, d4_vout, d4_dout, d4_lane, tbl[c % 4], c % 4);
        end
      end
    end
  endtask

  task automatic test_holes();
    logic [7:0][15:0] w;
    logic [7:0] xd;
    bit ev;
    logic [15:0] ed;
    int el;
    align4();
    w = '0;
    w[0] = 16'h11;
    w[2] = 16'h22;
    for (int c = 0; c < 16; c++) begin
      step4(w, (c % 4 == 0) ? 4'b0101 : 4'b0, 1'b0, ev, ed, el);
      checks++;
      if (d4_vout !== ev || d4_dout !== ed[7:0] ||
          d4_lane !== 2'(el)) begin
        errors++;
        $display("FAIL holes c=%0d: v/d/l=%b/%h/%0d want %b/%h/%0d",
                 c, d4_vout, d4_dout, d4_lane, ev, ed[7:0], el);
      end
      if (c >= 1) begin
        xd = (c % 4 == 0) ? 8'h11 : (c % 4 == 2) ? 8'h22 : 8'h00;
        checks++;
        if (d4_vout !== 1'(c % 2 == 0) || d4_lane !== 2'(c % 4) ||
            d4_dout !== xd) begin
          errors++;
          $display("FAIL holes_pat c=%0d: v/d/l=%b/%h/%0d want %b/%h/%0d",
                   c, d4_vout, d4_dout, d4_lane, c % 2 == 0, xd, c % 4);
        end
      end
    end
  endtask

  task automatic test_skip();
    logic [7:0][15:0] w;
    logic [1:0] prev;
    bit ev;
    logic [15:0] ed;
    int el;
    align4();
    w = '0;
    w[0] = 16'h11;
    w[2] = 16'h22;
    prev = 2'd1;
    for (int c = 0; c < 16; c++) begin
      step4(w, (c % 2 == 0) ? 4'b0101 : 4'b0, 1'b1, ev, ed, el);
      checks++;
      if (d4_vout !== ev || d4_dout !== ed[7:0] ||
          d4_lane !== 2'(el)) begin
        errors++;
        $display("FAIL skip c=%0d: v/d/l=%b/%h/%0d want %b/%h/%0d",
                 c, d4_vout, d4_dout, d4_lane, ev, ed[7:0], el);
      end
      if (c >= 1) begin
        checks++;
        if (d4_vout !== 1'b1 || (d4_lane !== 2'd0 && d4_lane !== 2'd2) ||
            d4_dout !== ((d4_lane == 2'd0) ? 8'h11 : 8'h22) ||
            (c >= 2 && d4_lane === prev)) begin
          errors++;
          $display("FAIL skip_pat c=%0d: v/d/l=%b/%h/%0d prev lane %0d",
                   c, d4_vout, d4_dout, d4_lane, prev);
        end
        prev = d4_lane;
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0][15:0] w;
    logic [7:0] got[$];
    bit ev;
    logic [15:0] ed;
    int el;
    align4();
    for (int c = 0; c < 20; c++) begin
      w = '0;
      w[3] = 16'(8'h30 + c);
      step4(w, (c < 8) ? 4'b1000 : 4'b0, 1'b0, ev, ed, el);
      if (d4_vout === 1'b1 && d4_lane === 2'd3) got.push_back(d4_dout);
      checks++;
      if (d4_vout !== ev || d4_dout !== ed[7:0] || d4_lane !== 2'(el) ||
          d4_ovf !== movf[3:0] || d4_rdy !== exp_rdy(4)[3:0]) begin
        errors++;
        $display("FAIL ovf_model c=%0d: v/d/l/o/r=%b/%h/%0d/%b/%b want %b/%h/%0d/%b",
                 c, d4_vout, d4_dout, d4_lane, d4_ovf, d4_rdy,
                 ev, ed[7:0], el, movf[3:0]);
      end
      if (c == 4) begin
        checks++;
        if (d4_rdy[3] !== 1'b0) begin
          errors++;
          $display("FAIL ovf_ready: in_ready[3]=%b want 0", d4_rdy[3]);
        end
      end
      if (c == 5) begin
        checks++;
        if (d4_ovf[3] !== 1'b1) begin
          errors++;
          $display("FAIL ovf_flag: overflow[3]=%b want 1", d4_ovf[3]);
        end
      end
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL ovf_count: lane3 words=%0d want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== 8'(8'h30 + i)) begin
          errors++;
          $display("FAIL ovf_order i=%0d: %h want %h", i, got[i], 8'h30 + i);
        end
      end
    end
    checks++;
    if (d4_ovf[3] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: overflow[3]=%b want 1", d4_ovf[3]);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0][15:0] w;
    bit ev;
    logic [15:0] ed;
    int el;
    align4();
    for (int i = 0; i < 4; i++) w[i] = 16'(8'h51 + i);
    for (int i = 4; i < 8; i++) w[i] = '0;
    step4(w, 4'hF, 1'b0, ev, ed, el);
    step4(w, 4'h0, 1'b0, ev, ed, el);
    checks++;
    if (d4_vout !== 1'b1 || d4_dout !== 8'h52) begin
      errors++;
      $display("FAIL midrst_pre: v/d=%b/%h want 1/52", d4_vout, d4_dout);
    end
    #2 rst4 = 1'b0;
    #1;
    checks++;
    if ({d4_vout, d4_dout, d4_lane, d4_ovf} !== 15'd0 ||
        d4_rdy !== 4'hF) begin
      errors++;
      $display("FAIL midrst_async: v/d/l/o/r=%b/%h/%0d/%b/%b want 0/0/0/0/1111",
               d4_vout, d4_dout, d4_lane, d4_ovf, d4_rdy);
    end
    @(posedge clk);
    #1 rst4 = 1'b1;
    model_reset();
    w = '0;
    w[2] = 16'h77;
    for (int c = 0; c < 8; c++) begin
      step4(w, (c == 1) ? 4'b0100 : 4'b0, 1'b0, ev, ed, el);
      checks++;
      if (d4_vout !== 1'(c == 2) || d4_dout !== ((c == 2) ? 8'h77 : 8'h0) ||
          d4_lane !== 2'(c % 4) || d4_vout !== ev) begin
        errors++;
        $display("FAIL midrst_post c=%0d: v/d/l=%b/%h/%0d want %b/%h/%0d",
                 c, d4_vout, d4_dout, d4_lane, c == 2,
                 (c == 2) ? 8'h77 : 8'h0, c % 4);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0][15:0] w;
    logic [7:0] v;
    bit sk;
    bit ev;
    logic [15:0] ed;
    int el;
    rst8 = 1'b0;
    @(posedge clk);
    #1 rst8 = 1'b1;
    model_reset();
    for (int c = 0; c < 900; c++) begin
      for (int i = 0; i < 8; i++) begin
        w[i] = 16'($urandom);
        v[i] = $urandom_range(0, 9) < ((c >= 600) ? 2 : 1);
      end
      sk = (c < 300) ? 1'b0 : (c < 600) ? 1'b1 : 1'($urandom_range(0, 1));
      step8(w, v, sk, ev, ed, el);
      checks++;
      if (d8_vout !== ev || d8_dout !== ed || d8_lane !== 3'(el) ||
          d8_ovf !== movf || d8_rdy !== exp_rdy(8)) begin
        errors++;
        $display("FAIL sweep c=%0d: v/d/l/o/r=%b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b",
                 c, d8_vout, d8_dout, d8_lane, d8_ovf, d8_rdy,
                 ev, ed, el, movf, exp_rdy(8));
      end
      if (c < 300) begin
        checks++;
        if (d8_lane !== 3'(c % 8)) begin
          errors++;
          $display("FAIL sweep_slot c=%0d: lane_out=%0d want %0d",
                   c, d8_lane, c % 8);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_holes();
    test_skip();
    test_overflow();
    test_mid_reset();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
